// File: rtl/serial_fa_ctrl.sv
// Bit-serial WIDTH-bit adder that time-shares one Fa_mux full-adder cell.
// Define SERIAL_FA_SUB_EN to add the sub port (a - b via inverted B, carry-in 1).

module Fa_mux (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_co
);
   logic w_p;
   assign w_p  = i_a ^ i_b;
   // Propagate selects: sum = ~c / c, carry = c / generate (a)
   assign o_s  = w_p ? ~i_c : i_c;
   assign o_co = w_p ? i_c : i_a;
endmodule

module serial_fa_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_FA_SUB_EN
   input  logic             sub,
`endif
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_s;
   logic             w_co;
   logic [WIDTH-1:0] w_b_ld;
   logic             w_c_ld;

`ifdef SERIAL_FA_SUB_EN
   assign w_b_ld = sub ? ~b : b;
   assign w_c_ld = sub ? 1'b1 : cin;
`else
   assign w_b_ld = b;
   assign w_c_ld = cin;
`endif

   Fa_mux u_fa (
      .i_a  (r_a[0]),
      .i_b  (r_b[0]),
      .i_c  (r_c),
      .o_s  (w_s),
      .o_co (w_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_c     <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= w_b_ld;
                  r_c     <= w_c_ld;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_acc <= {w_s, r_acc[WIDTH-1:1]};
               r_c   <= w_co;
               if (r_cnt == LAST) begin
                  // Publish result only on the final bit so sum stays stable
                  r_sum   <= {w_s, r_acc[WIDTH-1:1]};
                  r_cout  <= w_co;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;
endmodule

// File: tb/tb_serial_fa_ctrl.sv
// Self-checking bench for serial_fa_ctrl: directed plus random operations
// against an arithmetic reference model.

module tb_serial_fa_ctrl;
   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] prev_sum  = '0;
   logic         prev_cout = 1'b0;

   serial_fa_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_FA_SUB_EN
      .sub   (sub),
`endif
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {cout,sum} = a + b + cin, or a + ~b + 1 for subtract
   function automatic logic [W:0] model(input logic [W-1:0] ma,
      input logic [W-1:0] mb, input logic mc, input logic ms);
      int unsigned r;
      if (ms) r = int'(ma) + int'(~mb & {W{1'b1}}) + 1;
      else    r = int'(ma) + int'(mb) + int'(mc);
      return r[W:0];
   endfunction

   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts);
      logic [W:0] exp;
      int n;
      int nbusy;
      exp = model(ta, tb, tc, ts);
      @(negedge clk);
      start = 1'b1; a = ta; b = tb; cin = tc; sub = ts;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      chk("accept_busy", 32'(busy), 32'd1);
      chk("sum_held", 32'(sum), 32'(prev_sum));
      chk("cout_held", 32'(cout), 32'(prev_cout));
      n = 0;
      nbusy = busy ? 1 : 0;
      while (!done && n < W + 4) begin
         @(posedge clk); #1;
         n++;
         if (busy) nbusy++;
      end
      chk("latency", 32'(n), 32'(W));
      chk("busy_cycles", 32'(nbusy), 32'(W + 1));
      chk("sum", 32'(sum), 32'(exp[W-1:0]));
      chk("cout", 32'(cout), 32'(exp[W]));
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'd0);
      chk("busy_clear", 32'(busy), 32'd0);
      chk("sum_keep", 32'(sum), 32'(exp[W-1:0]));
      prev_sum  = exp[W-1:0];
      prev_cout = exp[W];
   endtask

   initial begin
      int ndone;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      @(negedge clk); rst = 1'b0;

      do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 1'b0);
      do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
      do_op(8'h00, 8'h00, 1'b0, 1'b0);

      // Continuous start: operands scrambled whenever busy
      ndone = 0;
      for (int i = 0; i < 3 * (W + 2); i++) begin
         @(negedge clk);
         start = 1'b1;
         if (busy) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         end else begin
            a = 8'h01; b = 8'h02; cin = 1'b0;
         end
         if (done) begin
            ndone++;
            chk("cont_sum", 32'(sum), 32'h03);
            chk("cont_cout", 32'(cout), 32'd0);
         end
      end
      @(negedge clk);
      start = 1'b0;
      chk("cont_dones", 32'(ndone), 32'd3);
      repeat (W + 3) @(negedge clk);
      prev_sum = 8'h03; prev_cout = 1'b0;

      // Reset during RUN abandons the operation
      @(negedge clk);
      start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1; #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_sum", 32'(sum), 32'd0);
      chk("mid_rst_cout", 32'(cout), 32'd0);
      @(negedge clk); rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("no_done_after_rst", 32'(ndone), 32'd0);
      prev_sum = '0; prev_cout = 1'b0;
      do_op(8'h12, 8'h34, 1'b0, 1'b0);

`ifdef SERIAL_FA_SUB_EN
      do_op(8'h10, 8'h01, 1'b0, 1'b1);
      do_op(8'h00, 8'h01, 1'b1, 1'b1);
      do_op(8'h10, 8'h01, 1'b0, 1'b0);
`endif

      for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_FA_SUB_EN
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
